// File: rtl/fifo_flush_vr.sv
// Valid/ready first-word fall-through FIFO with selectable flush mode,
// occupancy / almost-full status and a discarded-entry counter.
module fifo_flush_vr #(
  parameter int DW         = 16,
  parameter int DEPTH      = 4,
  parameter int AFULL_THR  = 3,
  parameter int FLUSH_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DW-1:0]              din_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [DW-1:0]              dout_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  input  logic                       flush_i,
  output logic                       flush_busy_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       almost_full_o,
  output logic [15:0]                flushed_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THR);
  localparam logic          DISCARD = (FLUSH_MODE == 0);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } st_t;

  st_t           r_state;
  st_t           w_state_nxt;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_flushed;

  logic          w_run;
  logic          w_push;
  logic          w_pop;
  logic          w_flush_clr;
  logic [16:0]   w_flush_sum;

  // State register; reset wins over any flush in progress.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: discard flush lasts one cycle, drain flush waits for empty.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN: begin
        if (flush_i) begin
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (DISCARD) begin
          w_state_nxt = RUN;
        end else if ((r_count == '0) ||
                     ((r_count == CW'(1)) && w_pop)) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Handshake outputs depend only on registered state, never on valid_i/ready_i.
  always_comb begin
    w_run        = (r_state == RUN);
    ready_o      = w_run && (r_count < DEPTH_C);
    valid_o      = (r_count != '0) && !(!w_run && DISCARD);
    flush_busy_o = !w_run;
    w_push       = valid_i && ready_o;
    w_pop        = valid_o && ready_i;
    w_flush_clr  = !w_run && DISCARD;
  end

  assign w_flush_sum = {1'b0, r_flushed} + 17'(r_count);

  // Pointers, occupancy and the discarded-entry counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_flushed <= '0;
    end else if (w_flush_clr) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_flushed <= w_flush_sum[16] ? 16'hFFFF : w_flush_sum[15:0];
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din_i;
    end
  end

  assign dout_o        = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign count_o       = r_count;
  assign almost_full_o = (r_count >= AFULL_C);
  assign flushed_cnt_o = r_flushed;

endmodule

// File: tb/tb_fifo_flush_vr.sv
// Directed scoreboard bench for fifo_flush_vr.
// u0 runs the discard flush mode, u1 the drain flush mode.
module tb_fifo_flush_vr;

  logic        clk = 1'b0;
  logic        rst;

  logic [15:0] din0, din1;
  logic        v0, v1, r0, r1, f0, f1;

  logic        rdy0, rdy1, vo0, vo1, bsy0, bsy1, af0, af1;
  logic [15:0] dout0, dout1, fc0, fc1;
  logic [2:0]  cnt0, cnt1;

  int total = 0;
  int bad   = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] words[4];
  logic [15:0] exp_w;

  always #5 clk = ~clk;

  fifo_flush_vr #(
    .DW(16), .DEPTH(4), .AFULL_THR(3), .FLUSH_MODE(0)
  ) u0 (
    .clk(clk), .rst(rst),
    .din_i(din0), .valid_i(v0), .ready_o(rdy0),
    .dout_o(dout0), .valid_o(vo0), .ready_i(r0),
    .flush_i(f0), .flush_busy_o(bsy0),
    .count_o(cnt0), .almost_full_o(af0),
    .flushed_cnt_o(fc0)
  );

  fifo_flush_vr #(
    .DW(16), .DEPTH(4), .AFULL_THR(3), .FLUSH_MODE(1)
  ) u1 (
    .clk(clk), .rst(rst),
    .din_i(din1), .valid_i(v1), .ready_o(rdy1),
    .dout_o(dout1), .valid_o(vo1), .ready_i(r1),
    .flush_i(f1), .flush_busy_o(bsy1),
    .count_o(cnt1), .almost_full_o(af1),
    .flushed_cnt_o(fc1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    words[0] = 16'hAAAA;
    words[1] = 16'hBBBB;
    words[2] = 16'hCCCC;
    words[3] = 16'hDDDD;
    rst = 1'b0;
    din0 = '0; din1 = '0;
    v0 = 0; v1 = 0; r0 = 0; r1 = 0; f0 = 0; f1 = 0;

    // 1. reset
    tick();
    tick();
    chk("rst_ready0", rdy0, 1);
    chk("rst_valid0", vo0, 0);
    chk("rst_count0", cnt0, 0);
    chk("rst_fcnt0", fc0, 0);
    chk("rst_busy0", bsy0, 0);
    chk("rst_afull0", af0, 0);
    chk("rst_dout0", dout0, 0);
    chk("rst_ready1", rdy1, 1);
    chk("rst_count1", cnt1, 0);
    rst = 1'b1;
    tick();

    // 2. fill to full with consumer stalled
    for (int i = 0; i < 4; i++) begin
      din0 = words[i];
      v0   = 1;
      #1;
      chk("fill_ready", rdy0, 1);
      chk("fill_count", cnt0, i);
      chk("fill_afull", af0, (i >= 3) ? 1 : 0);
      tick();
      q0.push_back(words[i]);
    end
    din0 = 16'hEEEE;
    #1;
    chk("full_ready", rdy0, 0);
    chk("full_count", cnt0, 4);
    chk("full_afull", af0, 1);
    chk("full_head", dout0, 16'hAAAA);
    tick();
    chk("full_noacc", cnt0, 4);
    v0 = 0;

    // 3. drain in order
    r0 = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_valid", vo0, 1);
      exp_w = q0.pop_front();
      chk("drain_data", dout0, exp_w);
      tick();
    end
    chk("drain_vend", vo0, 0);
    chk("drain_cend", cnt0, 0);
    chk("drain_dend", dout0, 0);
    r0 = 0;

    // 4. discard flush
    for (int i = 0; i < 3; i++) begin
      din0 = 16'h0011 * 16'(i + 1);
      v0   = 1;
      tick();
      q0.push_back(din0);
    end
    v0 = 0;
    chk("d_cnt3", cnt0, 3);
    f0 = 1;
    tick();
    f0 = 0;
    chk("d_busy", bsy0, 1);
    chk("d_valid", vo0, 0);
    chk("d_ready", rdy0, 0);
    tick();
    q0.delete();
    chk("d_busy_end", bsy0, 0);
    chk("d_cnt0", cnt0, 0);
    chk("d_fcnt", fc0, 3);
    chk("d_ready_end", rdy0, 1);
    din0 = 16'h1234;
    v0   = 1;
    tick();
    q0.push_back(16'h1234);
    v0 = 0;
    chk("d_pvalid", vo0, 1);
    exp_w = q0.pop_front();
    chk("d_pdata", dout0, exp_w);

    // 5. drain flush: entries leave, new push waits
    for (int i = 0; i < 3; i++) begin
      din1 = words[i];
      v1   = 1;
      tick();
      q1.push_back(words[i]);
    end
    v1 = 0;
    r1 = 1;
    f1 = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("f_valid", vo1, 1);
      exp_w = q1.pop_front();
      chk("f_data", dout1, exp_w);
      chk("f_busy", bsy1, (i == 0) ? 0 : 1);
      chk("f_ready", rdy1, (i == 0) ? 1 : 0);
      tick();
      f1   = 0;
      v1   = 1;
      din1 = 16'h5555;
    end
    chk("f_busy_end", bsy1, 0);
    chk("f_ready_end", rdy1, 1);
    chk("f_cnt_end", cnt1, 0);
    tick();
    q1.push_back(16'h5555);
    v1 = 0;
    chk("f_nvalid", vo1, 1);
    exp_w = q1.pop_front();
    chk("f_ndata", dout1, exp_w);
    chk("f_fcnt", fc1, 0);
    tick();
    chk("f_empty", cnt1, 0);
    r1 = 0;

    // 6. streaming at count 2 across pointer wrap
    for (int i = 0; i < 2; i++) begin
      din1 = 16'h0100 + 16'(i);
      v1   = 1;
      tick();
      q1.push_back(din1);
    end
    r1 = 1;
    for (int i = 0; i < 10; i++) begin
      din1 = 16'h0200 + 16'(i);
      #1;
      chk("s_count", cnt1, 2);
      chk("s_valid", vo1, 1);
      exp_w = q1.pop_front();
      chk("s_data", dout1, exp_w);
      tick();
      q1.push_back(din1);
    end
    v1 = 0;
    r1 = 0;
    chk("s_cnt_end", cnt1, 2);
    f1 = 1;
    tick();
    f1 = 0;
    chk("r_busy", bsy1, 1);
    rst = 0;
    tick();
    rst = 1;
    q1.delete();
    chk("r_busy0", bsy1, 0);
    chk("r_count0", cnt1, 0);
    chk("r_ready", rdy1, 1);
    chk("r_valid", vo1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
